uart_rx_deframer: RTL and testbench
===================================

// Module: uart_rx_deframer
// PURPOSE
//  Serial-to-parallel receive deframer for the UART RX path. Takes mid-bit samples from the RX
//  oversampler, detects the start bit, shifts in 5..MAX_W data bits (LSB first), checks the
//  optional parity and the stop bit, right-justifies the word and presents it on a valid/ready
//  port to the RX FIFO. Includes a one-word holding register, error flags and break detect.
// PARAMETERS
//  MAX_W  8  widest data word; data_out width
//  MIN_W  5  word length when wls==0; word length = MIN_W + wls (must be <= MAX_W)
//  WLS_W  2  width of the wls word-length select
// PORTS
//  clk        in   1        system clock
//  rst        in   1        synchronous active-high reset
//  bit_stb    in   1        one-cycle strobe: rx_bit holds a valid mid-bit sample
//  rx_bit     in   1        sampled serial line level
//  wls        in   WLS_W    word length select
//  pen        in   1        parity enable
//  eps        in   1        1 = even parity, 0 = odd parity
//  out_valid  out  1        holding register contains a word
//  out_ready  in   1        consumer accepts word when out_valid & out_ready
//  data_out   out  MAX_W    received word, right-justified, upper bits zero
//  parity_err out  1        parity mismatch for the held word
//  frame_err  out  1        stop bit sampled as 0 for the held word
//  break_det  out  1        held word is a break (all data, parity and stop bits 0)
//  overrun    out  1        one-cycle pulse: word completed while out_valid=1; word dropped
//  busy       out  1        FSM not in IDLE
// BEHAVIOUR
//  Reset: FSM=IDLE; out_valid, data_out, parity_err, frame_err, break_det, overrun, busy all 0.
//  All FSM transitions happen only on cycles with bit_stb=1; other cycles hold state.
//  IDLE: on bit_stb & rx_bit=0 -> DATA. Latch wls, pen, eps. Clear shift reg and bit count.
//    bit_stb & rx_bit=1 stays in IDLE.
//  DATA: each strobe shifts rx_bit into the MSB of the MAX_W shift reg (shift right).
//    After MIN_W+wls_l bits: go to PARITY if pen_l, else to STOP.
//  PARITY: captures the parity bit. Even: XOR(data, p) must be 0. Odd: it must be 1. -> STOP.
//  STOP: samples the stop bit. On the same strobe the word completes. FSM returns to IDLE.
//    The start of the next frame is detected only on a later strobe.
//  Completion: word = shift reg >> (MAX_W - len), zero-filled above len.
//    If out_valid=0, or out_valid & out_ready on that same cycle: load data_out and flags.
//    out_valid=1 from the next cycle, so latency is 1 clk after the stop strobe.
//    Otherwise keep the held word and flags, and pulse overrun for 1 cycle.
//  Flags: frame_err = ~stop.
//    break_det = data==0 & stop==0 & (parity==0 | ~pen_l).
//    parity_err is 0 when pen_l=0.
//  Handshake: out_valid & out_ready clears out_valid next cycle. data_out and flags hold their
//    value until the next load. out_valid must not drop without a handshake.
//  Config changes mid-frame have no effect; latched values apply until the frame ends.
//  rst mid-frame aborts the partial word and returns to IDLE. No word is emitted.
//  busy = (state != IDLE).
// TESTING
//  1 wls=00,pen=0; frame 0,1,0,1,1,0,1 -> data_out=0x0D 1 clk after the stop strobe; flags 0.
//  2 wls=11,pen=1,eps=1; data 0xA5, parity 0, stop 1 -> 0xA5, parity_err=0.
//    Repeat with parity 1 -> parity_err=1.
//  3 wls=10,pen=0; data 0x00, stop 0 -> data_out=0x00, frame_err=1, break_det=1.
//    Same frame with stop=1 -> break_det=0, frame_err=0.
//  4 out_ready=0; send 0x41 then 0x42 -> out_valid held with 0x41; overrun pulses once at the
//    second stop strobe. Then out_ready=1 -> 0x41 accepted, out_valid=0.
//  5 Stop strobe on the same cycle as accepting the old word -> new word loads, no overrun.
//  6 Assert rst after 3 data bits -> busy=0, out_valid=0, no word output. Next clean frame
//    0x3C with wls=11 -> 0x3C. Also change wls mid-frame -> length follows the latched wls.

Source files
------------

// File: rtl/uart_rx_deframer.sv
// ============================================================================
// Module  : uart_rx_deframer
// Purpose : UART receive deframer. It takes mid-bit samples, detects the start
//           bit, assembles 5..MAX_W data bits and checks parity and the stop
//           bit. The word is held in a one-entry valid/ready output register.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_rx_deframer #(
    parameter int MAX_W = 8,
    parameter int MIN_W = 5,
    parameter int WLS_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_stb,
    input  logic             rx_bit,
    input  logic [WLS_W-1:0] wls,
    input  logic             pen,
    input  logic             eps,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [MAX_W-1:0] data_out,
    output logic             parity_err,
    output logic             frame_err,
    output logic             break_det,
    output logic             overrun,
    output logic             busy
);

    localparam int CNT_W = $clog2(MAX_W + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    state_t           state;
    logic [MAX_W-1:0] shift_reg;
    logic [CNT_W-1:0] bit_cnt;
    logic [WLS_W-1:0] wls_l;
    logic             pen_l;
    logic             eps_l;
    logic             dpar;
    logic             par_bit;

    logic [CNT_W-1:0] len;
    logic [CNT_W-1:0] shamt;
    logic [MAX_W-1:0] word;
    logic             can_load;

    // Bits enter at the MSB, so a short word sits in the top of shift_reg
    // and is right-justified by shifting down by the unused width.
    always_comb begin
        len      = CNT_W'(MIN_W) + CNT_W'(wls_l);
        shamt    = CNT_W'(MAX_W) - len;
        word     = shift_reg >> shamt;
        can_load = ~out_valid | out_ready;
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            wls_l      <= '0;
            pen_l      <= 1'b0;
            eps_l      <= 1'b0;
            dpar       <= 1'b0;
            par_bit    <= 1'b0;
            out_valid  <= 1'b0;
            data_out   <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            break_det  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (bit_stb) begin
                case (state)
                    IDLE: begin
                        if (!rx_bit) begin
                            state     <= DATA;
                            wls_l     <= wls;
                            pen_l     <= pen;
                            eps_l     <= eps;
                            shift_reg <= '0;
                            bit_cnt   <= '0;
                            dpar      <= 1'b0;
                            par_bit   <= 1'b0;
                        end
                    end
                    DATA: begin
                        shift_reg <= {rx_bit, shift_reg[MAX_W-1:1]};
                        dpar      <= dpar ^ rx_bit;
                        bit_cnt   <= bit_cnt + CNT_W'(1);
                        if (bit_cnt == len - CNT_W'(1)) begin
                            state <= pen_l ? PARITY : STOP;
                        end
                    end
                    PARITY: begin
                        par_bit <= rx_bit;
                        state   <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        if (can_load) begin
                            out_valid  <= 1'b1;
                            data_out   <= word;
                            // Even parity wants total XOR 0, odd wants 1.
                            parity_err <= pen_l & (dpar ^ par_bit ^ ~eps_l);
                            frame_err  <= ~rx_bit;
                            break_det  <= (word == '0) & ~rx_bit & (~par_bit | ~pen_l);
                        end else begin
                            overrun <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_deframer.sv
// ============================================================================
// Module  : tb_uart_rx_deframer
// Purpose : Self-checking bench for uart_rx_deframer using an expected-word
//           queue that is filled as frames are sent and drained on handshakes.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_deframer;

    logic       clk = 1'b0;
    logic       rst;
    logic       bit_stb;
    logic       rx_bit;
    logic [1:0] wls;
    logic       pen;
    logic       eps;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] data_out;
    logic       parity_err;
    logic       frame_err;
    logic       break_det;
    logic       overrun;
    logic       busy;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        logic       bd;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   n_checks = 0;
    int   n_errors = 0;
    int   ovr_cnt  = 0;

    uart_rx_deframer #(.MAX_W(8), .MIN_W(5), .WLS_W(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .bit_stb    (bit_stb),
        .rx_bit     (rx_bit),
        .wls        (wls),
        .pen        (pen),
        .eps        (eps),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .data_out   (data_out),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .break_det  (break_det),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Inputs change just after posedge, so values seen at negedge are what the
    // DUT samples on the next posedge.
    always @(negedge clk) begin
        if (!rst && overrun) ovr_cnt++;
        if (!rst && out_valid && out_ready) begin
            if (q.size() == 0) begin
                check("unexpected_word", 32'(data_out), 32'hFFFF_FFFF);
            end else begin
                e = q.pop_front();
                check("data_out",   32'(data_out),   32'(e.d));
                check("parity_err", 32'(parity_err), 32'(e.pe));
                check("frame_err",  32'(frame_err),  32'(e.fe));
                check("break_det",  32'(break_det),  32'(e.bd));
            end
        end
    end

    task automatic send_bit(input logic b, input bit rdy_set);
        repeat (3) @(posedge clk);
        #1;
        bit_stb = 1'b1;
        rx_bit  = b;
        if (rdy_set) out_ready = 1'b1;
        @(posedge clk);
        #1;
        bit_stb = 1'b0;
        rx_bit  = 1'b1;
    endtask

    // Sends one frame using wls=w at the start bit, then switches wls to w_mid.
    task automatic send_frame(input logic [7:0] d, input logic [1:0] w, input logic [1:0] w_mid,
                              input logic p, input logic s, input bit drop, input bit rdy_at_stop);
        int   len;
        exp_t x;
        logic [7:0] dm;
        len = 5 + int'(w);
        dm  = 8'((int'(d)) & ((1 << len) - 1));
        wls = w;
        send_bit(1'b0, 1'b0);
        wls = w_mid;
        for (int i = 0; i < len; i++) send_bit(dm[i], 1'b0);
        if (pen) send_bit(p, 1'b0);
        if (!drop) begin
            x.d  = dm;
            x.pe = pen && ((^dm ^ p) != !eps);
            x.fe = !s;
            x.bd = (dm == 8'h00) && !s && (!pen || !p);
            q.push_back(x);
        end
        send_bit(s, rdy_at_stop);
        if (!drop) check("latency_valid", 32'(out_valid), 32'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || out_valid) && n < 60) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_queue_empty", 32'(q.size()), 32'd0);
        check("drain_valid_low", 32'(out_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        bit_stb   = 1'b0;
        rx_bit    = 1'b1;
        wls       = 2'b00;
        pen       = 1'b0;
        eps       = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid",   32'(out_valid),  32'd0);
        check("rst_data",    32'(data_out),   32'd0);
        check("rst_perr",    32'(parity_err), 32'd0);
        check("rst_ferr",    32'(frame_err),  32'd0);
        check("rst_break",   32'(break_det),  32'd0);
        check("rst_overrun", 32'(overrun),    32'd0);
        check("rst_busy",    32'(busy),       32'd0);
        rst = 1'b0;

        // 5-bit word 0x0D, no parity
        send_frame(8'h0D, 2'b00, 2'b00, 1'b0, 1'b1, 0, 0);
        check("t1_data_now", 32'(data_out), 32'h0D);
        drain();

        // 8-bit even parity, good then bad parity bit
        pen = 1'b1; eps = 1'b1;
        send_frame(8'hA5, 2'b11, 2'b11, 1'b0, 1'b1, 0, 0);
        send_frame(8'hA5, 2'b11, 2'b11, 1'b1, 1'b1, 0, 0);
        drain();

        // 7-bit break, then same data with valid stop
        pen = 1'b0;
        send_frame(8'h00, 2'b10, 2'b10, 1'b0, 1'b0, 0, 0);
        send_frame(8'h00, 2'b10, 2'b10, 1'b0, 1'b1, 0, 0);
        drain();

        // Overrun: consumer stalled
        out_ready = 1'b0;
        send_frame(8'h41, 2'b11, 2'b11, 1'b0, 1'b1, 0, 0);
        send_frame(8'h42, 2'b11, 2'b11, 1'b0, 1'b1, 1, 0);
        check("t4_overrun_pulse", 32'(overrun),   32'd1);
        check("t4_held_valid",    32'(out_valid), 32'd1);
        check("t4_held_data",     32'(data_out),  32'h41);
        @(posedge clk); #1;
        check("t4_overrun_once",  32'(overrun),   32'd0);
        out_ready = 1'b1;
        drain();
        check("t4_overrun_count", 32'(ovr_cnt), 32'd1);

        // Accept old word on the same edge the new one completes
        out_ready = 1'b0;
        send_frame(8'h11, 2'b11, 2'b11, 1'b0, 1'b1, 0, 0);
        send_frame(8'h22, 2'b11, 2'b11, 1'b0, 1'b1, 0, 1);
        check("t5_new_data", 32'(data_out), 32'h22);
        drain();
        check("t5_no_overrun", 32'(ovr_cnt), 32'd1);

        // Reset mid-frame, then clean frames with wls changed mid-frame
        wls = 2'b11;
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        check("t6_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("t6_busy_after",  32'(busy),      32'd0);
        check("t6_valid_after", 32'(out_valid), 32'd0);
        send_frame(8'h3C, 2'b11, 2'b00, 1'b0, 1'b1, 0, 0);
        send_frame(8'h15, 2'b00, 2'b11, 1'b0, 1'b1, 0, 0);
        drain();

        // Mixed random frames
        for (int k = 0; k < 8; k++) begin
            pen = 1'($urandom_range(0, 1));
            eps = 1'($urandom_range(0, 1));
            send_frame(8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)),
                       2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 0, 0);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
